// File: rtl/viper_mem_arbiter.sv
// Single-port memory arbiter/sequencer: shares one memory port between the VIPER core
// and a DMA requester, runs the strobe/ack handshake with a bounded wait, parks on timeout.
module viper_mem_arbiter #(
  parameter int AW      = 20,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_done,
  output logic [DW-1:0] core_rdata,
  input  logic          cpu_stop,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          fault,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} state_t;

  state_t        state, state_next;
  logic [7:0]    cnt, cnt_next, cnt_inc;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wdata_next;
  logic          mem_rd_next, mem_wr_next;
  logic          owner_next, fault_next;
  logic          core_done_next, dma_done_next;
  logic [DW-1:0] core_rdata_next, dma_rdata_next;
  logic          core_elig, dma_elig, grant_dma;

  assign core_elig = core_req & ~cpu_stop;
  assign dma_elig  = dma_req;
  // On a tie the requester that did not win last time is served.
  assign grant_dma = dma_elig & (~core_elig | ~owner);
  assign cnt_inc   = cnt + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      owner      <= 1'b1;
      fault      <= 1'b0;
      core_done  <= 1'b0;
      dma_done   <= 1'b0;
      core_rdata <= '0;
      dma_rdata  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      mem_rd     <= mem_rd_next;
      mem_wr     <= mem_wr_next;
      owner      <= owner_next;
      fault      <= fault_next;
      core_done  <= core_done_next;
      dma_done   <= dma_done_next;
      core_rdata <= core_rdata_next;
      dma_rdata  <= dma_rdata_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    mem_rd_next     = mem_rd;
    mem_wr_next     = mem_wr;
    owner_next      = owner;
    fault_next      = fault;
    core_done_next  = 1'b0;
    dma_done_next   = 1'b0;
    core_rdata_next = core_rdata;
    dma_rdata_next  = dma_rdata;

    case (state)
      IDLE: begin
        if (core_elig || dma_elig) begin
          owner_next = grant_dma;
          cnt_next   = '0;
          state_next = BUSY;
          if (grant_dma) begin
            mem_addr_next  = dma_addr;
            mem_wdata_next = dma_wdata;
            mem_rd_next    = ~dma_we;
            mem_wr_next    = dma_we;
          end else begin
            mem_addr_next  = core_addr;
            mem_wdata_next = core_wdata;
            mem_rd_next    = ~core_we;
            mem_wr_next    = core_we;
          end
        end
      end
      BUSY: begin
        // Ack wins over timeout when both land in the same cycle.
        if (mem_ack) begin
          if (mem_rd) begin
            if (owner) dma_rdata_next  = mem_rdata;
            else       core_rdata_next = mem_rdata;
          end
          mem_rd_next    = 1'b0;
          mem_wr_next    = 1'b0;
          core_done_next = ~owner;
          dma_done_next  = owner;
          state_next     = DONE;
        end else if (cnt_inc == 8'(TIMEOUT)) begin
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          fault_next  = 1'b1;
          state_next  = FAULT;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE: state_next = IDLE;
      FAULT: begin
        mem_rd_next = 1'b0;
        mem_wr_next = 1'b0;
        fault_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_viper_mem_arbiter.sv
// Directed bench for viper_mem_arbiter: arbitration, handshake timing, STOP, timeout, reset.
module tb_viper_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [19:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_done;
  logic [31:0] core_rdata;
  logic        cpu_stop = 1'b0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [19:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        fault, owner;

  int tests = 0;
  int fails = 0;

  viper_mem_arbiter #(.AW(20), .DW(32), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_done(core_done), .core_rdata(core_rdata), .cpu_stop(cpu_stop),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fault(fault), .owner(owner)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rd"}, mem_rd, 0);
    chk({tag, "_wr"}, mem_wr, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_cdone"}, core_done, 0);
    chk({tag, "_ddone"}, dma_done, 0);
    chk({tag, "_crdata"}, core_rdata, 0);
    chk({tag, "_drdata"}, dma_rdata, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_owner"}, owner, 1);
  endtask

  // Called in an IDLE cycle with requests applied; returns in the IDLE cycle after done.
  task automatic serve(input string tag, input logic exp_owner, input logic [19:0] exp_addr,
                       input logic [31:0] rd);
    tick();
    chk({tag, "_owner"}, owner, exp_owner);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_rd"}, mem_rd, 1);
    mem_ack = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_strobe_low"}, mem_rd, 0);
    chk({tag, "_core_done"}, core_done, !exp_owner);
    chk({tag, "_dma_done"}, dma_done, exp_owner);
    if (exp_owner) chk({tag, "_dma_rdata"}, dma_rdata, rd);
    else           chk({tag, "_core_rdata"}, core_rdata, rd);
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk_reset_values("rst");
    tick();

    // Core read, ack in cycle 1
    core_req = 1; core_we = 0; core_addr = 20'h00008;
    tick();
    chk("t1_rd_c1", mem_rd, 1);
    chk("t1_addr", mem_addr, 20'h00008);
    chk("t1_owner", owner, 0);
    chk("t1_nodone_c1", core_done, 0);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0; core_req = 0;
    chk("t1_rd_c2", mem_rd, 0);
    chk("t1_done_c2", core_done, 1);
    chk("t1_rdata", core_rdata, 32'hDEADBEEF);
    chk("t1_dma_rdata", dma_rdata, 0);
    tick();
    chk("t1_done_c3", core_done, 0);
    chk("t1_rdata_held", core_rdata, 32'hDEADBEEF);

    // Ack outside BUSY is ignored
    mem_ack = 1; mem_rdata = 32'h11111111;
    tick();
    tick();
    mem_ack = 0;
    chk("stray_ack_done", core_done | dma_done, 0);
    chk("stray_ack_rdata", core_rdata, 32'hDEADBEEF);

    // Fresh reset, simultaneous core write + DMA read, ack delay 2 cycles
    reset = 1; tick(); reset = 0;
    core_req = 1; core_we = 1; core_addr = 20'h00010; core_wdata = 32'h12345678;
    dma_req = 1;  dma_we = 0;  dma_addr = 20'h00020;
    tick();
    chk("t2_owner_core", owner, 0);
    chk("t2_wr", mem_wr, 1);
    chk("t2_rd", mem_rd, 0);
    chk("t2_addr", mem_addr, 20'h00010);
    chk("t2_wdata", mem_wdata, 32'h12345678);
    tick();
    chk("t2_wr_held", mem_wr, 1);
    chk("t2_addr_held", mem_addr, 20'h00010);
    mem_ack = 1;
    tick();
    mem_ack = 0; core_req = 0;
    chk("t2_core_done", core_done, 1);
    chk("t2_dma_done0", dma_done, 0);
    chk("t2_wr_low", mem_wr, 0);
    chk("t2_core_rdata_wr", core_rdata, 0);
    tick();
    tick();
    chk("t2_owner_dma", owner, 1);
    chk("t2_dma_rd", mem_rd, 1);
    chk("t2_dma_addr", mem_addr, 20'h00020);
    tick();
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0; dma_req = 0;
    chk("t2_dma_done", dma_done, 1);
    chk("t2_dma_rdata", dma_rdata, 32'hCAFEF00D);
    chk("t2_core_rdata_kept", core_rdata, 0);
    tick();

    // Both held: grants alternate core, DMA, core
    core_req = 1; core_we = 0; core_addr = 20'h00030;
    dma_req = 1;  dma_we = 0;  dma_addr = 20'h00040;
    serve("alt1", 0, 20'h00030, 32'hA0000001);
    serve("alt2", 1, 20'h00040, 32'hA0000002);
    serve("alt3", 0, 20'h00030, 32'hA0000003);

    // cpu_stop: DMA granted every time, even when the core would win the tie
    cpu_stop = 1;
    serve("stop1", 1, 20'h00040, 32'hB0000001);
    serve("stop2", 1, 20'h00040, 32'hB0000002);
    chk("stop_core_rdata", core_rdata, 32'hA0000003);

    // cpu_stop raised during a core BUSY: access completes
    cpu_stop = 0; dma_req = 0;
    tick();
    chk("stopbusy_owner", owner, 0);
    cpu_stop = 1;
    tick();
    chk("stopbusy_rd", mem_rd, 1);
    mem_ack = 1; mem_rdata = 32'hC0000001;
    tick();
    mem_ack = 0; core_req = 0; cpu_stop = 0;
    chk("stopbusy_done", core_done, 1);
    chk("stopbusy_rdata", core_rdata, 32'hC0000001);
    tick();

    // Ack exactly in cycle TIMEOUT succeeds
    core_req = 1; core_addr = 20'h00050;
    tick();
    for (int c = 2; c <= 15; c++) tick();
    chk("edge_rd_c15", mem_rd, 1);
    mem_ack = 1; mem_rdata = 32'hD0000015;
    tick();
    mem_ack = 0; core_req = 0;
    chk("edge_done", core_done, 1);
    chk("edge_fault", fault, 0);
    chk("edge_rdata", core_rdata, 32'hD0000015);
    tick();

    // Timeout: strobe cycles 1..15, fault from 16, then parked
    core_req = 1; core_addr = 20'h00060;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("to_rd_c%0d", c), mem_rd, 1);
      chk($sformatf("to_fault_c%0d", c), fault, 0);
    end
    tick();
    chk("to_rd_c16", mem_rd, 0);
    chk("to_fault_c16", fault, 1);
    chk("to_nodone", core_done, 0);
    core_req = 0; dma_req = 1; dma_addr = 20'h00070;
    tick();
    tick();
    tick();
    chk("park_rd", mem_rd | mem_wr, 0);
    chk("park_fault", fault, 1);
    chk("park_nodone", dma_done | core_done, 0);
    chk("park_rdata", core_rdata, 32'hD0000015);
    dma_req = 0;

    // Reset exits FAULT; then async reset mid-BUSY
    reset = 1; tick(); reset = 0;
    chk_reset_values("rst2");
    core_req = 1; core_we = 0; core_addr = 20'h00080;
    tick();
    chk("mid_rd", mem_rd, 1);
    reset = 1;
    #1;
    chk("mid_rd_async", mem_rd, 0);
    chk("mid_owner_async", owner, 1);
    tick();
    reset = 0;
    core_req = 0;
    chk_reset_values("rst3");
    core_req = 1; core_addr = 20'h00090;
    dma_req = 1;  dma_addr = 20'h000A0;
    serve("post_rst", 0, 20'h00090, 32'hE0000001);
    core_req = 0; dma_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
